mdu_div_iter: RTL

//  Iterative RV32M/RV64M divide unit (DIV, DIVU, REM, REMU) for the EX stage of the 5-stage core.

---
 rtl/mdu_div_iter_pkg.sv | 22 ++
 rtl/mdu_div_iter_div_step.sv | 36 +++
 rtl/mdu_div_iter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mdu_div_iter_pkg.sv
// Shared definitions for the iterative divide unit: operation encodings
// (funct3[1:0]) and the controller state encoding.
package mdu_div_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MDU_OP_DIV  = 2'b00;
    localparam logic [1:0] MDU_OP_DIVU = 2'b01;
    localparam logic [1:0] MDU_OP_REM  = 2'b10;
    localparam logic [1:0] MDU_OP_REMU = 2'b11;

    // Low bit of the op code clear means a signed operation (DIV, REM).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_div_iter_div_step.sv
// One restoring-division step: shifts the next dividend MSB (taken from the
// top of the quotient/dividend shifter) into the partial remainder, trial
// subtracts the divisor and retires one quotient bit into the shifter LSB.
module mdu_div_iter_div_step
    import mdu_div_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    // The incoming remainder is always below the divisor, so its MSB is zero.
    logic            unused_rem_msb;

    assign unused_rem_msb = rem_in[XLEN];

    // Shift, trial subtract, and restore when the subtraction borrows.
    always_comb begin
        shifted = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        if (trial[XLEN+1]) begin
            rem_out = shifted;
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = trial[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative RV32M/RV64M divider (DIV, DIVU, REM, REMU). Works on operand
// magnitudes with a restoring algorithm retiring BPC quotient bits per
// cycle, then fixes signs in a single FIXUP cycle. Divide-by-zero and the
// signed overflow case are answered directly with one-cycle latency.
module mdu_div_iter
    import mdu_div_iter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int K  = XLEN / BPC;
    localparam int CW = $clog2(K) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CW-1:0]   counter;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;           // dividend shifts out of the top, quotient in at the bottom
    logic [XLEN-1:0] divisor_mag;
    logic            neg_q;
    logic            neg_r;
    logic            op_rem;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    // Combinational chain of BPC restoring steps per CALC cycle.
    logic [XLEN:0]   rem_chain [BPC+1];
    logic [XLEN-1:0] quo_chain [BPC+1];

    assign rem_chain[0] = rem;
    assign quo_chain[0] = quo;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_step
            mdu_div_iter_div_step #(.XLEN(XLEN)) u_step (
                .rem_in  (rem_chain[gi]),
                .quo_in  (quo_chain[gi]),
                .divisor (divisor_mag),
                .rem_out (rem_chain[gi+1]),
                .quo_out (quo_chain[gi+1])
            );
        end
    endgenerate

    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // Operand decode for launch, and sign fixup of the finished quotient/remainder.
    // Negation is modulo 2^XLEN, so |MIN_INT| comes out as the unsigned magnitude.
    always_comb begin
        sign_a   = is_signed_op(op_i) & dividend_i[XLEN-1];
        sign_b   = is_signed_op(op_i) & divisor_i[XLEN-1];
        a_mag    = sign_a ? -dividend_i : dividend_i;
        b_mag    = sign_b ? -divisor_i  : divisor_i;
        div_zero = (divisor_i == '0);
        overflow = is_signed_op(op_i) && (dividend_i == MIN_INT) && (divisor_i == '1);
        q_fix    = neg_q ? -quo : quo;
        r_fix    = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    end

    // Controller: flush wins over everything, otherwise step through the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            counter     <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_mag <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            op_rem      <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            result      <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    valid <= 1'b0;
                    if (start_i) begin
                        if (div_zero) begin
                            result <= op_i[1] ? dividend_i : '1;
                            valid  <= 1'b1;
                            state  <= ST_DONE;
                        end else if (overflow) begin
                            result <= op_i[1] ? '0 : MIN_INT;
                            valid  <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            divisor_mag <= b_mag;
                            quo         <= a_mag;
                            rem         <= '0;
                            neg_q       <= sign_a ^ sign_b;
                            neg_r       <= sign_a;
                            op_rem      <= op_i[1];
                            counter     <= CW'(K);
                            busy        <= 1'b1;
                            state       <= ST_CALC;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem     <= rem_chain[BPC];
                    quo     <= quo_chain[BPC];
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        state <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result <= op_rem ? r_fix : q_fix;
                    busy   <= 1'b0;
                    valid  <= 1'b1;
                    state  <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy;
    assign valid_o  = valid;
    assign result_o = result;

endmodule
